// File: rtl/alu_muldiv.sv
// Execute-stage ALU. Logic, shift and compare ops finish in one cycle. Multiply
// and divide are iterative, signed or unsigned, and write the HI/LO registers.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [4:0]       ALUCtrl,
  input  logic             Sign,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic             zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_NOR  = 5'd5;
  localparam logic [4:0] OP_SL   = 5'd6;
  localparam logic [4:0] OP_SR   = 5'd7;
  localparam logic [4:0] OP_COMP = 5'd8;
  localparam logic [4:0] OP_MUL  = 5'd10;
  localparam logic [4:0] OP_DIV  = 5'd11;
  localparam logic [4:0] OP_MFHI = 5'd12;
  localparam logic [4:0] OP_MFLO = 5'd13;

  typedef enum logic [2:0] {S_IDLE, S_EXEC1, S_MUL, S_DIV, S_FIN} state_t;

  state_t             state_reg, state_next;
  logic [4:0]         op_reg;
  logic               sign_reg;
  logic [WIDTH-1:0]   a_reg, b_reg;
  logic [CW-1:0]      cnt_reg;
  logic [2*WIDTH-1:0] prod_reg;
  logic [WIDTH-1:0]   mcand_reg;
  logic [WIDTH-1:0]   out_reg, hi_reg, lo_reg;
  logic               zero_reg, done_reg;

  assign done = done_reg;
  assign out  = out_reg;
  assign zero = zero_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= S_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    ready      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        ready = 1'b1;
        if (start) begin
          if (ALUCtrl == OP_MUL)      state_next = S_MUL;
          else if (ALUCtrl == OP_DIV) state_next = S_DIV;
          else                        state_next = S_EXEC1;
        end
      end
      S_EXEC1:      state_next = S_IDLE;
      S_MUL, S_DIV: if (cnt_reg == CW'(WIDTH)) state_next = S_FIN;
      S_FIN:        state_next = S_IDLE;
      default:      state_next = S_IDLE;
    endcase
  end

  // Single-cycle result from the captured operands.
  logic [SW-1:0]    shamt;
  logic             less;
  logic [WIDTH-1:0] alu_res;
  assign shamt = a_reg[SW-1:0];
  assign less  = sign_reg ? ($signed(a_reg) < $signed(b_reg)) : (a_reg < b_reg);

  always_comb begin
    alu_res = '0;
    case (op_reg)
      OP_ADD:  alu_res = a_reg + b_reg;
      OP_SUB:  alu_res = a_reg - b_reg;
      OP_AND:  alu_res = a_reg & b_reg;
      OP_OR:   alu_res = a_reg | b_reg;
      OP_XOR:  alu_res = a_reg ^ b_reg;
      OP_NOR:  alu_res = ~(a_reg | b_reg);
      OP_SL:   alu_res = b_reg << shamt;
      OP_SR: begin
        if (sign_reg) alu_res = $signed(b_reg) >>> shamt;
        else          alu_res = b_reg >> shamt;
      end
      OP_COMP: alu_res = {{(WIDTH-1){1'b0}}, less};
      OP_MFHI: alu_res = hi_reg;
      OP_MFLO: alu_res = lo_reg;
      default: alu_res = '0;
    endcase
  end

  // Magnitudes, one iteration step of each algorithm, and sign fix-up.
  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0] fin_hi, fin_lo;

  assign a_neg     = sign_reg & a_reg[WIDTH-1];
  assign b_neg     = sign_reg & b_reg[WIDTH-1];
  assign a_mag     = a_neg ? -a_reg : a_reg;
  assign b_mag     = b_neg ? -b_reg : b_reg;
  assign mul_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                   + ({(WIDTH+1){prod_reg[0]}} & {1'b0, mcand_reg});
  assign div_shift = prod_reg[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, mcand_reg};
  assign mul_res   = (a_neg ^ b_neg) ? -prod_reg : prod_reg;

  always_comb begin
    fin_hi = mul_res[2*WIDTH-1:WIDTH];
    fin_lo = mul_res[WIDTH-1:0];
    if (op_reg == OP_DIV) begin
      if (b_reg == '0) begin
        fin_hi = a_reg;
        fin_lo = '1;
      end else begin
        fin_hi = a_neg ? -prod_reg[2*WIDTH-1:WIDTH] : prod_reg[2*WIDTH-1:WIDTH];
        fin_lo = (a_neg ^ b_neg) ? -prod_reg[WIDTH-1:0] : prod_reg[WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg    <= '0;
      sign_reg  <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      cnt_reg   <= '0;
      prod_reg  <= '0;
      mcand_reg <= '0;
      out_reg   <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      zero_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            op_reg   <= ALUCtrl;
            sign_reg <= Sign;
            a_reg    <= in1;
            b_reg    <= in2;
            cnt_reg  <= '0;
          end
        end
        S_EXEC1: begin
          out_reg  <= alu_res;
          zero_reg <= (op_reg == OP_SUB) && (alu_res == '0);
          done_reg <= 1'b1;
        end
        S_MUL, S_DIV: begin
          cnt_reg <= cnt_reg + CW'(1);
          // First cycle loads magnitudes; the following WIDTH cycles iterate.
          if (cnt_reg == '0) begin
            prod_reg  <= {{WIDTH{1'b0}}, (state_reg == S_MUL) ? b_mag : a_mag};
            mcand_reg <= (state_reg == S_MUL) ? a_mag : b_mag;
          end else if (state_reg == S_MUL) begin
            prod_reg <= {mul_sum, prod_reg[WIDTH-1:1]};
          end else begin
            prod_reg <= {div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0],
                         prod_reg[WIDTH-2:0], ~div_diff[WIDTH]};
          end
        end
        S_FIN: begin
          hi_reg   <= fin_hi;
          lo_reg   <= fin_lo;
          out_reg  <= fin_lo;
          zero_reg <= 1'b0;
          done_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// Directed self-checking bench for alu_muldiv at WIDTH=32 plus a WIDTH=16 instance.
module tb_alu_muldiv;
  logic        clk = 1'b0;
  logic        reset, start, sign;
  logic [4:0]  alu_ctrl;
  logic [31:0] in1, in2, out, hi, lo;
  logic        ready, done, zero;

  logic        start16;
  logic [4:0]  alu_ctrl16;
  logic        sign16;
  logic [15:0] in1_16, in2_16, out16, hi16, lo16;
  logic        ready16, done16, zero16;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .ALUCtrl(alu_ctrl), .Sign(sign),
    .in1(in1), .in2(in2), .ready(ready), .done(done), .out(out), .zero(zero),
    .hi(hi), .lo(lo)
  );

  alu_muldiv #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .ALUCtrl(alu_ctrl16), .Sign(sign16),
    .in1(in1_16), .in2(in2_16), .ready(ready16), .done(done16), .out(out16),
    .zero(zero16), .hi(hi16), .lo(lo16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Issue one op in the current cycle and wait (bounded) for its done pulse.
  task automatic run_op(input logic [4:0] op, input logic sg, input logic [31:0] a,
                        input logic [31:0] b, output int lat);
    check("ready_before_start", ready, 1'b1);
    alu_ctrl = op; sign = sg; in1 = a; in2 = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; alu_ctrl = 5'd0; sign = ~sg; in1 = $urandom; in2 = $urandom;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("op=%0d sign=%0d a=%h b=%h -> out=%h zero=%b hi=%h lo=%h lat=%0d",
             op, sg, a, b, out, zero, hi, lo, lat);
  endtask

  typedef struct {
    logic [4:0]  op;
    logic        sg;
    logic [31:0] a, b, y;
    logic        z;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input logic [4:0] op, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] y, input logic z);
    vec_t v;
    v.op = op; v.sg = sg; v.a = a; v.b = b; v.y = y; v.z = z;
    vecs.push_back(v);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int dones;
    reset = 1'b1; start = 1'b0; alu_ctrl = '0; sign = 1'b0; in1 = '0; in2 = '0;
    start16 = 1'b0; alu_ctrl16 = '0; sign16 = 1'b0; in1_16 = '0; in2_16 = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    check("rst_ready", ready, 1'b1);
    check("rst_done", done, 1'b0);
    check("rst_out", out, 32'h0);
    check("rst_zero", zero, 1'b0);
    check("rst_hi", hi, 32'h0);
    check("rst_lo", lo, 32'h0);

    run_op(5'd10, 1'b0, 32'hFFFF_FFFF, 32'h2, lat);
    check("umul_lat", lat, 34);
    check("umul_hi", hi, 32'h1);
    check("umul_lo", lo, 32'hFFFF_FFFE);
    check("umul_out", out, 32'hFFFF_FFFE);

    // Reset ten cycles into a MUL: no done, everything cleared.
    alu_ctrl = 5'd10; sign = 1'b0; in1 = 7; in2 = 9; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dones = 0;
    repeat (9) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_ready", ready, 1'b1);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    check("abort_out", out, 32'h0);
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("abort_no_done", dones, 0);
    run_op(5'd0, 1'b0, 3, 4, lat);
    check("add_after_abort_lat", lat, 1);
    check("add_after_abort_out", out, 32'd7);

    run_op(5'd10, 1'b1, 32'hFFFF_FFFD, 32'd5, lat);
    check("smul_lat", lat, 34);
    check("smul_hi", hi, 32'hFFFF_FFFF);
    check("smul_lo", lo, 32'hFFFF_FFF1);
    check("smul_out", out, 32'hFFFF_FFF1);

    add_vec(5'd0,  1'b0, 32'hFFFF_FFFF, 32'h2,         32'h1,         1'b0);
    add_vec(5'd1,  1'b0, 32'd5,         32'd5,         32'h0,         1'b1);
    add_vec(5'd1,  1'b0, 32'd5,         32'd6,         32'hFFFF_FFFF, 1'b0);
    add_vec(5'd2,  1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0);
    add_vec(5'd3,  1'b0, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'hFFFF_F0F0, 1'b0);
    add_vec(5'd4,  1'b0, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0);
    add_vec(5'd5,  1'b0, 32'h0,         32'h0000_FFFF, 32'hFFFF_0000, 1'b0);
    add_vec(5'd6,  1'b0, 32'd4,         32'd1,         32'h10,        1'b0);
    add_vec(5'd6,  1'b0, 32'h24,        32'd3,         32'h30,        1'b0);
    add_vec(5'd7,  1'b1, 32'd4,         32'h8000_0000, 32'hF800_0000, 1'b0);
    add_vec(5'd7,  1'b0, 32'd4,         32'h8000_0000, 32'h0800_0000, 1'b0);
    add_vec(5'd8,  1'b1, 32'hFFFF_FFFF, 32'd1,         32'h1,         1'b0);
    add_vec(5'd8,  1'b0, 32'hFFFF_FFFF, 32'd1,         32'h0,         1'b0);
    add_vec(5'd0,  1'b0, 32'h0,         32'h0,         32'h0,         1'b0);
    add_vec(5'd9,  1'b0, 32'd3,         32'd4,         32'h0,         1'b0);
    add_vec(5'd12, 1'b0, 32'd3,         32'd4,         32'hFFFF_FFFF, 1'b0);
    add_vec(5'd31, 1'b0, 32'd3,         32'd4,         32'h0,         1'b0);
    add_vec(5'd13, 1'b0, 32'd3,         32'd4,         32'hFFFF_FFF1, 1'b0);
    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].sg, vecs[i].a, vecs[i].b, lat);
      check($sformatf("v%0d_lat", i), lat, 1);
      check($sformatf("v%0d_out", i), out, vecs[i].y);
      check($sformatf("v%0d_zero", i), zero, vecs[i].z);
      check($sformatf("v%0d_hi", i), hi, 32'hFFFF_FFFF);
      check($sformatf("v%0d_lo", i), lo, 32'hFFFF_FFF1);
    end

    run_op(5'd11, 1'b1, 32'hFFFF_FFF9, 32'd2, lat);
    check("sdiv_lat", lat, 34);
    check("sdiv_lo", lo, 32'hFFFF_FFFD);
    check("sdiv_hi", hi, 32'hFFFF_FFFF);
    check("sdiv_out", out, 32'hFFFF_FFFD);
    run_op(5'd11, 1'b0, 32'd12, 32'd0, lat);
    check("div0_lat", lat, 34);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'd12);
    run_op(5'd11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat);
    check("sovf_lo", lo, 32'h8000_0000);
    check("sovf_hi", hi, 32'h0);
    run_op(5'd11, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, lat);
    check("udiv_big_lo", lo, 32'h1);
    check("udiv_big_hi", hi, 32'h7FFF_FFFF);

    // start held high with changing inputs while busy, then MFLO in the done cycle.
    alu_ctrl = 5'd11; sign = 1'b0; in1 = 32'd100; in2 = 32'd7; start = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (!done && lat < 100) begin
      alu_ctrl = 5'd10; sign = 1'b1; in1 = $urandom; in2 = $urandom;
      @(posedge clk); #1;
      lat++;
    end
    $display("held-start DIV 100/7 -> lo=%h hi=%h lat=%0d", lo, hi, lat);
    check("held_lat", lat, 34);
    check("held_lo", lo, 32'd14);
    check("held_hi", hi, 32'd2);
    check("held_ready_at_done", ready, 1'b1);
    alu_ctrl = 5'd13; sign = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("MFLO in done cycle -> out=%h lat=%0d", out, lat);
    check("mflo_b2b_lat", lat, 1);
    check("mflo_b2b_out", out, 32'd14);
    dones = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) dones++;
    end
    check("held_no_extra_done", dones, 0);

    alu_ctrl16 = 5'd10; sign16 = 1'b0; in1_16 = 16'hFFFF; in2_16 = 16'hFFFF; start16 = 1'b1;
    @(posedge clk); #1;
    start16 = 1'b0; in1_16 = 16'h0; in2_16 = 16'h0;
    lat = 0;
    while (!done16 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    $display("W16 MUL FFFF*FFFF -> hi=%h lo=%h lat=%0d", hi16, lo16, lat);
    check("w16_lat", lat, 18);
    check("w16_hi", hi16, 16'hFFFE);
    check("w16_lo", lo16, 16'h0001);
    check("w16_out", out16, 16'h0001);
    check("w16_zero", zero16, 1'b0);
    check("w16_ready", ready16, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
